// File: rtl/coil_pulse_sequencer.sv
// coil_pulse_sequencer
//
// Turns a 32-bit GPIO control word into a timed pulse train on one coil-drive
// line and reports progress through a 32-bit status word that feeds back into
// the same GPIO. The busy bit drops on the same clock edge as the final drive
// fall, so a falling-edge capture on status[0] marks completion.
//
// Ports:
//   clk          system clock (same domain as the GPIO, inputs not synchronised)
//   reset_n      asynchronous active-low reset, clears every register
//   ctrl_word    [7:0] on_ticks, [15:8] off_ticks, [23:16] pulse_count,
//                [27:24] channel, [29:28] reserved, [30] abort, [31] start
//   status_word  [0] busy, [1] aborted, [2] cfg_error, [3] drive_active,
//                [15:8] pulses_remaining, [19:16] active_channel, others 0
//   coil_drive   one-hot active-high drive outputs, NCH wide
//
// Control interface: start is edge-triggered (0->1 seen on a clock edge),
// abort is a level that wins over start whenever both are present.
// The FSM state is held in r_state (ST_IDLE / ST_ON / ST_OFF).

module coil_pulse_sequencer #(
  parameter int NCH      = 8,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      ctrl_word,
  output logic [31:0]      status_word,
  output logic [NCH-1:0]   coil_drive
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic             r_start_d;
  logic [PW-1:0]    r_presc;
  logic [7:0]       r_tick_cnt;
  logic [7:0]       r_on_ticks;
  logic [7:0]       r_off_ticks;
  logic [3:0]       r_channel;
  logic [7:0]       r_rem;
  logic             r_busy;
  logic             r_aborted;
  logic             r_cfg_error;
  logic             r_drive_active;
  logic [NCH-1:0]   r_coil;

  // Next-state values
  state_t           w_state_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic [7:0]       w_tick_cnt_nxt;
  logic [7:0]       w_on_ticks_nxt;
  logic [7:0]       w_off_ticks_nxt;
  logic [3:0]       w_channel_nxt;
  logic [7:0]       w_rem_nxt;
  logic             w_busy_nxt;
  logic             w_aborted_nxt;
  logic             w_cfg_error_nxt;
  logic             w_drive_active_nxt;
  logic [NCH-1:0]   w_coil_nxt;

  // Control word fields
  logic [7:0]       w_on_in;
  logic [7:0]       w_off_in;
  logic [7:0]       w_cnt_in;
  logic [3:0]       w_ch_in;
  logic             w_abort;
  logic             w_start_edge;
  logic             w_cfg_invalid;
  logic             w_tick;
  logic [7:0]       w_off_len;
  logic             w_phase_last;
  logic             w_unused_ctrl;

  assign w_on_in      = ctrl_word[7:0];
  assign w_off_in     = ctrl_word[15:8];
  assign w_cnt_in     = ctrl_word[23:16];
  assign w_ch_in      = ctrl_word[27:24];
  assign w_abort      = ctrl_word[30];
  assign w_start_edge = ctrl_word[31] & ~r_start_d;
  assign w_unused_ctrl = ^ctrl_word[29:28];

  assign w_cfg_invalid = (w_cnt_in == 8'd0) || (w_on_in == 8'd0) ||
                         ({1'b0, w_ch_in} >= 5'(NCH));

  // One tick per PRESCALE clocks; the prescaler only advances while a
  // sequence is running and restarts from 0 on every accepted start.
  assign w_tick = (r_presc == PRESC_LAST);

  // A zero off time still produces a one-tick gap between pulses.
  assign w_off_len = (r_off_ticks == 8'd0) ? 8'd1 : r_off_ticks;

  assign w_phase_last = (r_state == ST_ON) ? (r_tick_cnt == r_on_ticks - 8'd1)
                                           : (r_tick_cnt == w_off_len - 8'd1);

  function automatic logic [NCH-1:0] onehot(input logic [3:0] ch);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_presc_nxt        = r_presc;
    w_tick_cnt_nxt     = r_tick_cnt;
    w_on_ticks_nxt     = r_on_ticks;
    w_off_ticks_nxt    = r_off_ticks;
    w_channel_nxt      = r_channel;
    w_rem_nxt          = r_rem;
    w_busy_nxt         = r_busy;
    w_aborted_nxt      = r_aborted;
    w_cfg_error_nxt    = r_cfg_error;
    w_drive_active_nxt = r_drive_active;
    w_coil_nxt         = r_coil;

    case (r_state)
      ST_IDLE: begin
        if (w_start_edge && !w_abort) begin
          if (w_cfg_invalid) begin
            w_cfg_error_nxt = 1'b1;
            w_aborted_nxt   = 1'b0;
          end else begin
            w_on_ticks_nxt     = w_on_in;
            w_off_ticks_nxt    = w_off_in;
            w_channel_nxt      = w_ch_in;
            w_rem_nxt          = w_cnt_in;
            w_cfg_error_nxt    = 1'b0;
            w_aborted_nxt      = 1'b0;
            w_presc_nxt        = '0;
            w_tick_cnt_nxt     = 8'd0;
            w_state_nxt        = ST_ON;
            w_busy_nxt         = 1'b1;
            w_drive_active_nxt = 1'b1;
            w_coil_nxt         = onehot(w_ch_in);
          end
        end
      end

      ST_ON, ST_OFF: begin
        if (w_abort) begin
          // pulses_remaining deliberately keeps its value for post-mortem.
          w_state_nxt        = ST_IDLE;
          w_busy_nxt         = 1'b0;
          w_drive_active_nxt = 1'b0;
          w_coil_nxt         = '0;
          w_aborted_nxt      = 1'b1;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            if (w_phase_last) begin
              w_tick_cnt_nxt = 8'd0;
              if (r_state == ST_ON) begin
                w_rem_nxt          = r_rem - 8'd1;
                w_coil_nxt         = '0;
                w_drive_active_nxt = 1'b0;
                if (r_rem == 8'd1) begin
                  // Last pulse: busy falls together with the drive.
                  w_state_nxt = ST_IDLE;
                  w_busy_nxt  = 1'b0;
                end else begin
                  w_state_nxt = ST_OFF;
                end
              end else begin
                w_state_nxt        = ST_ON;
                w_coil_nxt         = onehot(r_channel);
                w_drive_active_nxt = 1'b1;
              end
            end else begin
              w_tick_cnt_nxt = r_tick_cnt + 8'd1;
            end
          end
        end
      end

      default: begin
        w_state_nxt        = ST_IDLE;
        w_busy_nxt         = 1'b0;
        w_drive_active_nxt = 1'b0;
        w_coil_nxt         = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_start_d      <= 1'b0;
      r_presc        <= '0;
      r_tick_cnt     <= 8'd0;
      r_on_ticks     <= 8'd0;
      r_off_ticks    <= 8'd0;
      r_channel      <= 4'd0;
      r_rem          <= 8'd0;
      r_busy         <= 1'b0;
      r_aborted      <= 1'b0;
      r_cfg_error    <= 1'b0;
      r_drive_active <= 1'b0;
      r_coil         <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_start_d      <= ctrl_word[31];
      r_presc        <= w_presc_nxt;
      r_tick_cnt     <= w_tick_cnt_nxt;
      r_on_ticks     <= w_on_ticks_nxt;
      r_off_ticks    <= w_off_ticks_nxt;
      r_channel      <= w_channel_nxt;
      r_rem          <= w_rem_nxt;
      r_busy         <= w_busy_nxt;
      r_aborted      <= w_aborted_nxt;
      r_cfg_error    <= w_cfg_error_nxt;
      r_drive_active <= w_drive_active_nxt;
      r_coil         <= w_coil_nxt;
    end
  end

  assign coil_drive  = r_coil;
  assign status_word = {12'd0, r_channel, r_rem, 4'd0,
                        r_drive_active, r_cfg_error, r_aborted, r_busy};

endmodule

// File: tb/tb_coil_pulse_sequencer.sv
// Directed testbench for coil_pulse_sequencer. Two instances share the clock
// and reset: dut (PRESCALE=4) and dut1 (PRESCALE=1).

module tb_coil_pulse_sequencer;

  localparam int NCH = 8;

  // Clock and reset
  logic           clk = 1'b0;
  logic           reset_n;
  logic [31:0]    ctrl_word;
  logic [31:0]    status_word;
  logic [NCH-1:0] coil_drive;
  logic [31:0]    ctrl1;
  logic [31:0]    status1;
  logic [NCH-1:0] coil1;

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  coil_pulse_sequencer #(.NCH(NCH), .PRESCALE(4)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_word(ctrl_word),
    .status_word(status_word), .coil_drive(coil_drive)
  );

  coil_pulse_sequencer #(.NCH(NCH), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ctrl_word(ctrl1),
    .status_word(status1), .coil_drive(coil1)
  );

  function automatic logic [31:0] mk_ctrl(input bit start, input bit abort,
      input int ch, input int cnt, input int off, input int on);
    logic [31:0] w;
    w = '0;
    w[31]    = start;
    w[30]    = abort;
    w[27:24] = ch[3:0];
    w[23:16] = cnt[7:0];
    w[15:8]  = off[7:0];
    w[7:0]   = on[7:0];
    return w;
  endfunction

  function automatic logic [31:0] mk_status(input bit busy, input bit ab,
      input bit cfg, input bit da, input int rem, input int ch);
    logic [31:0] s;
    s = '0;
    s[0]     = busy;
    s[1]     = ab;
    s[2]     = cfg;
    s[3]     = da;
    s[15:8]  = rem[7:0];
    s[19:16] = ch[3:0];
    return s;
  endfunction

  function automatic logic [NCH-1:0] drive_of(input logic hi, input int ch);
    logic [NCH-1:0] v;
    v = '0;
    if (hi) v[ch] = 1'b1;
    return v;
  endfunction

  // Reference train timing. t = number of clock edges since the edge that
  // accepted the start; on_c/off_c are phase lengths in clocks (off already
  // forced to at least one tick).
  function automatic void train_model(input int t, input int on_c,
      input int off_c, input int cnt, output logic hi, output logic bsy,
      output int rem);
    int per;
    int total;
    int idx;
    int ph;
    per   = on_c + off_c;
    total = cnt * on_c + (cnt - 1) * off_c;
    if (t >= total) begin
      hi = 1'b0; bsy = 1'b0; rem = 0;
    end else begin
      idx = t / per;
      ph  = t % per;
      hi  = (ph < on_c);
      bsy = 1'b1;
      rem = cnt - idx - ((ph >= on_c) ? 1 : 0);
    end
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    ctrl_word = '0;
    ctrl1     = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (status_word !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status got=%h exp=%h", status_word, 32'h0);
    end
    tests_run++;
    if (coil_drive !== '0) begin
      tests_failed++;
      $display("FAIL reset_drive got=%b exp=%b", coil_drive, 8'b0);
    end
    tests_run++;
    if (status1 !== 32'h0 || coil1 !== '0) begin
      tests_failed++;
      $display("FAIL reset_dut1 got=%h/%b exp=0/0", status1, coil1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (status_word !== 32'h0 || coil_drive !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle got=%h/%b exp=0/0", status_word, coil_drive);
    end
  endtask

  task automatic test_nominal(input string name);
    logic hi;
    logic bsy;
    int   rem;
    int   busy_cycles;
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word   = mk_ctrl(1, 0, 5, 3, 3, 2);
    busy_cycles = 0;
    for (int t = 0; t < 56; t++) begin
      @(negedge clk);
      train_model(t, 8, 12, 3, hi, bsy, rem);
      tests_run++;
      if (coil_drive !== drive_of(hi, 5)) begin
        tests_failed++;
        $display("FAIL %s_drive t=%0d got=%b exp=%b", name, t, coil_drive, drive_of(hi, 5));
      end
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 5)) begin
        tests_failed++;
        $display("FAIL %s_status t=%0d got=%h exp=%h", name, t, status_word,
                 mk_status(bsy, 0, 0, hi, rem, 5));
      end
      if (status_word[0]) busy_cycles++;
    end
    tests_run++;
    if (busy_cycles !== 48) begin
      tests_failed++;
      $display("FAIL %s_busy_len got=%0d exp=%0d", name, busy_cycles, 48);
    end
    ctrl_word = '0;
  endtask

  task automatic test_cfg_error();
    int cnt;
    int on;
    int ch;
    logic hi;
    logic bsy;
    int   rem;
    for (int c = 0; c < 3; c++) begin
      cnt = (c == 0) ? 0 : 2;
      on  = (c == 1) ? 0 : 1;
      ch  = (c == 2) ? 9 : 1;
      ctrl_word = '0;
      @(negedge clk);
      ctrl_word = mk_ctrl(1, 0, ch, cnt, 1, on);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        tests_run++;
        if (status_word !== mk_status(0, 0, 1, 0, 0, 5)) begin
          tests_failed++;
          $display("FAIL cfg_err%0d_status k=%0d got=%h exp=%h", c, k, status_word,
                   mk_status(0, 0, 1, 0, 0, 5));
        end
        tests_run++;
        if (coil_drive !== '0) begin
          tests_failed++;
          $display("FAIL cfg_err%0d_drive k=%0d got=%b exp=0", c, k, coil_drive);
        end
      end
    end
    // A valid start afterwards clears the error flag.
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 2, 1, 1, 1);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      train_model(t, 4, 4, 1, hi, bsy, rem);
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 2) ||
          coil_drive !== drive_of(hi, 2)) begin
        tests_failed++;
        $display("FAIL cfg_recover t=%0d got=%h/%b exp=%h/%b", t, status_word, coil_drive,
                 mk_status(bsy, 0, 0, hi, rem, 2), drive_of(hi, 2));
      end
    end
    ctrl_word = '0;
  endtask

  task automatic test_abort();
    logic hi;
    logic bsy;
    int   rem;
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 3, 4, 3, 2);
    for (int t = 0; t <= 22; t++) begin
      @(negedge clk);
      train_model(t, 8, 12, 4, hi, bsy, rem);
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 3) ||
          coil_drive !== drive_of(hi, 3)) begin
        tests_failed++;
        $display("FAIL abort_pre t=%0d got=%h/%b exp=%h/%b", t, status_word, coil_drive,
                 mk_status(bsy, 0, 0, hi, rem, 3), drive_of(hi, 3));
      end
    end
    // Mid second ON phase: pulses_remaining is 3 here.
    ctrl_word = mk_ctrl(1, 1, 3, 4, 3, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (status_word !== mk_status(0, 1, 0, 0, 3, 3) || coil_drive !== '0) begin
        tests_failed++;
        $display("FAIL abort_post k=%0d got=%h/%b exp=%h/0", k, status_word, coil_drive,
                 mk_status(0, 1, 0, 0, 3, 3));
      end
    end
    // Abort and start edge together from IDLE: nothing starts.
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 1, 1, 2, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (status_word !== mk_status(0, 1, 0, 0, 3, 3) || coil_drive !== '0) begin
        tests_failed++;
        $display("FAIL abort_start k=%0d got=%h/%b exp=%h/0", k, status_word, coil_drive,
                 mk_status(0, 1, 0, 0, 3, 3));
      end
    end
    // Releasing abort with start still high is not a new edge.
    ctrl_word = mk_ctrl(1, 0, 1, 2, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (status_word !== mk_status(0, 1, 0, 0, 3, 3) || coil_drive !== '0) begin
        tests_failed++;
        $display("FAIL abort_release k=%0d got=%h/%b exp=%h/0", k, status_word, coil_drive,
                 mk_status(0, 1, 0, 0, 3, 3));
      end
    end
    ctrl_word = '0;
  endtask

  task automatic test_retrigger();
    logic hi;
    logic bsy;
    int   rem;
    // Start held high through completion: one train only.
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 1, 2, 1, 1);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      train_model(t, 4, 4, 2, hi, bsy, rem);
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 1) ||
          coil_drive !== drive_of(hi, 1)) begin
        tests_failed++;
        $display("FAIL retrig_held t=%0d got=%h/%b exp=%h/%b", t, status_word, coil_drive,
                 mk_status(bsy, 0, 0, hi, rem, 1), drive_of(hi, 1));
      end
    end
    // Start toggled while busy with a different config: ignored.
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 6, 2, 1, 2);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      train_model(t, 8, 4, 2, hi, bsy, rem);
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 6) ||
          coil_drive !== drive_of(hi, 6)) begin
        tests_failed++;
        $display("FAIL retrig_busy t=%0d got=%h/%b exp=%h/%b", t, status_word, coil_drive,
                 mk_status(bsy, 0, 0, hi, rem, 6), drive_of(hi, 6));
      end
      if (t == 3) ctrl_word = mk_ctrl(0, 0, 0, 1, 0, 1);
      if (t == 5) ctrl_word = mk_ctrl(1, 0, 0, 1, 0, 1);
    end
    // Fresh edge after completion starts a new train.
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 0, 1, 0, 1);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      train_model(t, 4, 4, 1, hi, bsy, rem);
      tests_run++;
      if (status_word !== mk_status(bsy, 0, 0, hi, rem, 0) ||
          coil_drive !== drive_of(hi, 0)) begin
        tests_failed++;
        $display("FAIL retrig_new t=%0d got=%h/%b exp=%h/%b", t, status_word, coil_drive,
                 mk_status(bsy, 0, 0, hi, rem, 0), drive_of(hi, 0));
      end
    end
    ctrl_word = '0;
  endtask

  task automatic test_off_zero();
    logic hi;
    logic bsy;
    int   rem;
    int   busy_cycles;
    ctrl1 = '0;
    @(negedge clk);
    ctrl1       = mk_ctrl(1, 0, 4, 2, 0, 1);
    busy_cycles = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      train_model(t, 1, 1, 2, hi, bsy, rem);
      tests_run++;
      if (status1 !== mk_status(bsy, 0, 0, hi, rem, 4) || coil1 !== drive_of(hi, 4)) begin
        tests_failed++;
        $display("FAIL off_zero t=%0d got=%h/%b exp=%h/%b", t, status1, coil1,
                 mk_status(bsy, 0, 0, hi, rem, 4), drive_of(hi, 4));
      end
      if (status1[0]) busy_cycles++;
    end
    tests_run++;
    if (busy_cycles !== 3) begin
      tests_failed++;
      $display("FAIL off_zero_busy_len got=%0d exp=%0d", busy_cycles, 3);
    end
    ctrl1 = '0;
  endtask

  task automatic test_async_reset();
    ctrl_word = '0;
    @(negedge clk);
    ctrl_word = mk_ctrl(1, 0, 5, 3, 3, 2);
    repeat (4) @(negedge clk);
    tests_run++;
    if (coil_drive !== drive_of(1'b1, 5)) begin
      tests_failed++;
      $display("FAIL areset_pre got=%b exp=%b", coil_drive, drive_of(1'b1, 5));
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (coil_drive !== '0 || status_word !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_immediate got=%h/%b exp=0/0", status_word, coil_drive);
    end
    @(negedge clk);
    tests_run++;
    if (coil_drive !== '0 || status_word !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_held got=%h/%b exp=0/0", status_word, coil_drive);
    end
    ctrl_word = '0;
    reset_n   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (coil_drive !== '0 || status_word !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_idle got=%h/%b exp=0/0", status_word, coil_drive);
    end
    test_nominal("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal("nominal");
    test_cfg_error();
    test_abort();
    test_retrigger();
    test_off_zero();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
